// File: rtl/led_frame_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_fetch_pkg
// Brief    : Shared types and default widths for the LED frame fetch block.
// Revision : 1.0
// ============================================================================
package led_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ZDONE = 2'd3
    } state_t;

    localparam int DEF_ADDR_W     = 13;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 14;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W     = $clog2(DEF_FIFO_DEPTH) + 1;

    // Count must hold the value DEPTH itself, hence the extra bit.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_fetch_if
// Brief    : Memory read port and Avalon-ST source bundle of the frame fetcher.
// Revision : 1.0
// ============================================================================
interface led_frame_fetch_if
    import led_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;

    modport master (
        output m_address, m_chipselect, m_clken,
        input  m_readdata,
        output src_data, src_valid, src_sop, src_eop,
        input  src_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_clken,
        output m_readdata,
        input  src_data, src_valid, src_sop, src_eop,
        output src_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_frame_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : led_fetch_fifo
// Brief    : Synchronous FIFO with registered show-ahead output and flush.
// Revision : 1.0
// ============================================================================
module led_fetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                i_flush,
    input  wire                i_wr_en,
    input  wire   [DATA_W-1:0] i_wr_data,
    input  wire                i_rd_en,
    output logic  [DATA_W-1:0] o_rd_data,
    output logic               o_valid,
    output logic  [CNT_W-1:0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_mem_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic w_load;
    logic w_mem_nonempty;
    logic w_bypass;
    logic w_push;
    logic w_pull;

    // Output stage refills whenever it is empty or its word is leaving.
    assign w_load         = !r_out_valid || i_rd_en;
    assign w_mem_nonempty = (r_mem_cnt != '0);
    assign w_bypass       = i_wr_en && w_load && !w_mem_nonempty;
    assign w_push         = i_wr_en && !w_bypass;
    assign w_pull         = w_load && w_mem_nonempty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pull) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_mem_cnt <= r_mem_cnt + CNT_W'(w_push) - CNT_W'(w_pull);
            if (w_load) begin
                if (w_pull) begin
                    r_out_data  <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_out_data  <= i_wr_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_rd_data = r_out_data;
    assign o_valid   = r_out_valid;
    assign o_count   = r_mem_cnt + CNT_W'(r_out_valid);
endmodule
`default_nettype wire

// File: rtl/led_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_fetch
// Brief    : Reads a run of words from fixed-latency memory, emits one ST packet.
// Revision : 1.0
// ============================================================================
module led_frame_fetch
    import led_fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    input  wire                 abort,
    input  wire   [ADDR_W-1:0]  base_addr,
    input  wire   [LEN_W-1:0]   word_count,
    output logic                busy,
    output logic                done,
    led_frame_fetch_if.master   bus
);
    localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_reads_left;
    logic [LEN_W-1:0]  r_beats_left;
    logic              r_first;
    logic              r_inflight;
    logic              r_done;

    logic              w_accept;
    logic              w_done_set;
    logic              w_cs;
    logic              w_room;
    logic              w_xfer;
    logic              w_last_beat;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_valid;
    logic [CNT_W-1:0]  w_fifo_count;

    // Words buffered plus the read still in flight must leave a free slot.
    assign w_room      = (SUM_W'(w_fifo_count) + SUM_W'(r_inflight)) < SUM_W'(FIFO_DEPTH);
    assign w_cs        = (r_state == FETCH) && (r_reads_left != '0) && w_room && !abort;
    assign w_xfer      = w_fifo_valid && bus.src_ready;
    assign w_last_beat = (r_beats_left == LEN_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            IDLE, ZDONE: begin
                w_state_next = IDLE;
                if (start && !abort) begin
                    if (word_count != '0) begin
                        w_state_next = FETCH;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = ZDONE;
                        w_done_set   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_cs && (r_reads_left == LEN_W'(1))) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_xfer && w_last_beat) begin
                    w_state_next = IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_reads_left <= '0;
            r_beats_left <= '0;
            r_first      <= 1'b0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_inflight <= w_cs;
            r_done     <= w_done_set;
            if (w_accept) begin
                r_addr       <= base_addr;
                r_reads_left <= word_count;
                r_beats_left <= word_count;
                r_first      <= 1'b1;
            end else begin
                if (w_cs) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_reads_left <= r_reads_left - LEN_W'(1);
                end
                if (w_xfer) begin
                    r_beats_left <= r_beats_left - LEN_W'(1);
                    r_first      <= 1'b0;
                end
            end
        end
    end

    // Abort flushes; the flush beats the write of any returning read data.
    led_fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_flush   (abort),
        .i_wr_en   (r_inflight),
        .i_wr_data (bus.m_readdata),
        .i_rd_en   (bus.src_ready),
        .o_rd_data (w_fifo_data),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    assign busy             = (r_state == FETCH) || (r_state == DRAIN);
    assign done             = r_done;
    assign bus.m_address    = r_addr;
    assign bus.m_chipselect = w_cs;
    assign bus.m_clken      = 1'b1;
    assign bus.src_data     = w_fifo_data;
    assign bus.src_valid    = w_fifo_valid;
    assign bus.src_sop      = w_fifo_valid && r_first;
    assign bus.src_eop      = w_fifo_valid && w_last_beat;
endmodule
`default_nettype wire

// File: tb/tb_led_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_fetch
// Brief    : Directed self-checking bench for led_frame_fetch.
// Revision : 1.0
// ============================================================================
module tb_led_frame_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [12:0] base_addr;
    logic [13:0] word_count;
    logic        busy;
    logic        done;

    led_frame_fetch_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    led_frame_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] beat_q [$];
    logic [1:0]  flag_q [$];
    int          cyc_q  [$];
    logic [12:0] addr_q [$];
    int          done_cnt = 0;
    int          cs_viol  = 0;
    int          occ      = 0;
    int          cyc      = 0;

    // Memory word k holds 0xA5000000 + k, returned one cycle after the read.
    always @(posedge clk) begin
        if (bus.m_chipselect) bus.m_readdata <= 32'hA500_0000 | {19'd0, bus.m_address};
    end

    // occ = words buffered or in flight, tracked from the pins.
    always @(negedge clk) begin
        cyc++;
        if (bus.m_chipselect) begin
            addr_q.push_back(bus.m_address);
            if (occ >= 4) cs_viol++;
        end
        if (bus.src_valid && bus.src_ready) begin
            beat_q.push_back(bus.src_data);
            flag_q.push_back({bus.src_sop, bus.src_eop});
            cyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
        if (reset || abort) occ = 0;
        else occ = occ + int'(bus.m_chipselect) - int'(bus.src_valid && bus.src_ready);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [12:0] b, input logic [13:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done) break;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic check_packet(input string tag, input int first, input int n, input logic [12:0] b);
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            if (first + i < beat_q.size()) begin
                a = b + 13'(i);
                check({tag, "_data"}, beat_q[first+i], 32'hA500_0000 | {19'd0, a});
                check({tag, "_sop_eop"}, flag_q[first+i], {i == 0, i == n - 1});
            end
        end
    endtask

    initial begin
        int b0, a0, d0, v0, b1;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0; bus.src_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cs", bus.m_chipselect, 1'b0);
        check("rst_addr", bus.m_address, 13'h0);
        check("rst_valid", bus.src_valid, 1'b0);
        check("rst_sop", bus.src_sop, 1'b0);
        check("rst_eop", bus.src_eop, 1'b0);
        reset = 1'b0;
        tick();

        // Nominal 8-word run
        b0 = beat_q.size(); d0 = done_cnt; v0 = cs_viol;
        pulse_start(13'h0010, 14'd8);
        check("t1_busy", busy, 1'b1);
        check("t1_cs", bus.m_chipselect, 1'b1);
        check("t1_addr", bus.m_address, 13'h0010);
        tick();
        check("t1_valid_c2", bus.src_valid, 1'b0);
        tick();
        check("t1_valid_c3", bus.src_valid, 1'b1);
        check("t1_data_c3", bus.src_data, 32'hA500_0010);
        check("t1_sop_c3", bus.src_sop, 1'b1);
        wait_done("t1", 40);
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_len", beat_q.size() - b0, 8);
        check_packet("t1", b0, 8, 13'h0010);
        if (beat_q.size() >= b0 + 8) check("t1_contig", cyc_q[b0+7] - cyc_q[b0], 7);
        check("t1_done_cnt", done_cnt - d0, 1);

        // Backpressure toggling every cycle
        b0 = beat_q.size(); d0 = done_cnt;
        pulse_start(13'h0020, 14'd16);
        for (int i = 0; i < 200; i++) begin
            bus.src_ready = ~bus.src_ready;
            tick();
            if (done) break;
        end
        check("t2_done", done, 1'b1);
        bus.src_ready = 1'b1;
        tick();
        check("t2_len", beat_q.size() - b0, 16);
        check_packet("t2", b0, 16, 13'h0020);
        check("t2_done_cnt", done_cnt - d0, 1);

        // Backpressure held low for 20 cycles
        b0 = beat_q.size(); a0 = addr_q.size();
        bus.src_ready = 1'b0;
        pulse_start(13'h0040, 14'd16);
        repeat (20) tick();
        check("t3_reads_stalled", addr_q.size() - a0, 4);
        check("t3_no_beats", beat_q.size() - b0, 0);
        check("t3_hold_valid", bus.src_valid, 1'b1);
        check("t3_hold_data", bus.src_data, 32'hA500_0040);
        check("t3_hold_flags", {bus.src_sop, bus.src_eop}, 2'b10);
        bus.src_ready = 1'b1;
        wait_done("t3", 60);
        tick();
        check("t3_len", beat_q.size() - b0, 16);
        check_packet("t3", b0, 16, 13'h0040);
        check("t123_cs_rule", cs_viol - v0, 0);

        // Address wrap
        b0 = beat_q.size(); a0 = addr_q.size();
        pulse_start(13'h1FFE, 14'd4);
        wait_done("t4", 30);
        tick();
        check("t4_nreads", addr_q.size() - a0, 4);
        if (addr_q.size() >= a0 + 4) begin
            check("t4_addr0", addr_q[a0],   13'h1FFE);
            check("t4_addr1", addr_q[a0+1], 13'h1FFF);
            check("t4_addr2", addr_q[a0+2], 13'h0000);
            check("t4_addr3", addr_q[a0+3], 13'h0001);
        end
        check("t4_len", beat_q.size() - b0, 4);
        check_packet("t4", b0, 4, 13'h1FFE);

        // Single word
        b0 = beat_q.size();
        pulse_start(13'h0007, 14'd1);
        wait_done("t5", 20);
        tick();
        check("t5_len", beat_q.size() - b0, 1);
        check_packet("t5", b0, 1, 13'h0007);

        // Zero words
        a0 = addr_q.size(); d0 = done_cnt;
        pulse_start(13'h0055, 14'd0);
        check("t6_done", done, 1'b1);
        check("t6_busy", busy, 1'b0);
        tick();
        check("t6_done_pulse", done, 1'b0);
        repeat (3) tick();
        check("t6_no_reads", addr_q.size() - a0, 0);
        check("t6_done_cnt", done_cnt - d0, 1);

        // Abort on cycle 5 of a 32-word fetch, then fresh fetch
        d0 = done_cnt;
        pulse_start(13'h0200, 14'd32);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_busy", busy, 1'b0);
        check("t7_valid", bus.src_valid, 1'b0);
        repeat (5) tick();
        check("t7_no_done", done_cnt - d0, 0);
        check("t7_valid_later", bus.src_valid, 1'b0);
        b1 = beat_q.size();
        pulse_start(13'h0100, 14'd2);
        wait_done("t7b", 20);
        tick();
        check("t7b_len", beat_q.size() - b1, 2);
        check_packet("t7b", b1, 2, 13'h0100);

        // Same with reset in place of abort
        d0 = done_cnt;
        pulse_start(13'h0200, 14'd32);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t8_busy", busy, 1'b0);
        check("t8_valid", bus.src_valid, 1'b0);
        check("t8_done", done, 1'b0);
        repeat (5) tick();
        check("t8_no_done", done_cnt - d0, 0);
        b1 = beat_q.size();
        pulse_start(13'h0100, 14'd2);
        wait_done("t8b", 20);
        tick();
        check("t8b_len", beat_q.size() - b1, 2);
        check_packet("t8b", b1, 2, 13'h0100);

        // Start while busy is ignored
        b0 = beat_q.size(); d0 = done_cnt;
        pulse_start(13'h0300, 14'd3);
        pulse_start(13'h0050, 14'd9);
        wait_done("t9", 30);
        repeat (3) tick();
        check("t9_len", beat_q.size() - b0, 3);
        check_packet("t9", b0, 3, 13'h0300);
        check("t9_done_cnt", done_cnt - d0, 1);
        check("t9_idle", busy, 1'b0);

        // Start in the done cycle
        b0 = beat_q.size();
        pulse_start(13'h0400, 14'd2);
        wait_done("t10a", 20);
        pulse_start(13'h0500, 14'd2);
        check("t10_busy", busy, 1'b1);
        check("t10_cs", bus.m_chipselect, 1'b1);
        check("t10_addr", bus.m_address, 13'h0500);
        wait_done("t10b", 20);
        tick();
        check("t10_len", beat_q.size() - b0, 4);
        check_packet("t10a", b0, 2, 13'h0400);
        check_packet("t10b", b0 + 2, 2, 13'h0500);

        // Start with abort in IDLE
        b0 = beat_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        abort = 1'b1;
        pulse_start(13'h0600, 14'd5);
        abort = 1'b0;
        check("t11_busy", busy, 1'b0);
        repeat (4) tick();
        check("t11_no_reads", addr_q.size() - a0, 0);
        check("t11_no_beats", beat_q.size() - b0, 0);
        check("t11_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/led_frame_fetch.md
Name: led_frame_fetch

Overview:
- Avalon-MM read master and stream source sitting directly downstream of the 8192x32 on-chip pixel/program memory.
- Fetches a contiguous run of 32-bit words (one packed pixel per word) from the memory's fixed-latency slave port.
- Buffers the words in a small FIFO and presents them as an Avalon-ST packet to the LED pixel serializer.
- Software triggers one frame fetch per start pulse.

Parameters:
- ADDR_W, 13, word-address width of the memory slave (8192 words).
- DATA_W, 32, memory and stream data width.
- LEN_W, 14, width of word_count (max 8192 words per frame).
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a fetch when idle.
- abort  in  1  one-cycle pulse; cancels the current fetch.
- base_addr  in  ADDR_W  first word address, sampled on an accepted start.
- word_count  in  LEN_W  number of words, sampled on an accepted start.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the last beat is accepted.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  read strobe (write is never driven; this master only reads).
- m_clken  out  1  memory clock enable; constant 1 out of reset.
- m_readdata  in  DATA_W  memory data; valid exactly 1 cycle after a chipselect cycle.
- src_data  out  DATA_W  stream data.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready (Avalon-ST, ready latency 0).
- src_sop  out  1  start of packet, qualified by src_valid.
- src_eop  out  1  end of packet, qualified by src_valid.

Behaviour:
- Reset values: busy=0, done=0, m_chipselect=0, m_address=0, src_valid=0, src_sop=0, src_eop=0. FIFO empty, in-flight flag cleared, state IDLE.
- States and transitions:
  - IDLE: start with word_count>0 latches base_addr and word_count, then moves to FETCH.
  - IDLE: start with word_count==0 moves to ZDONE.
  - ZDONE: pulses done for one cycle, makes no memory access, returns to IDLE.
  - FETCH: moves to DRAIN once the last read has been issued.
  - DRAIN: returns to IDLE in the cycle after the eop beat is accepted.
- start is ignored while busy.
- Issue rule: m_chipselect=1 in a cycle only when reads_left>0 and fifo_count + inflight < FIFO_DEPTH.
  - inflight is 1 if chipselect was high in the previous cycle.
  - At most one read per cycle. Reads are never lost to FIFO overflow.
- m_readdata is written into the FIFO in the cycle after each chipselect cycle.
- The FIFO output is registered: a word written in cycle N is visible on src_data in cycle N+1.
- Latency: start accepted at edge 0 → chipselect in cycle 1 → FIFO write in cycle 2 → src_valid in cycle 3.
- Sustained throughput with src_ready=1 is 1 word/clk.
- Address increments by 1 per issued read, modulo 2^ADDR_W (8191 wraps to 0).
- src_sop is 1 on the first beat of the packet, src_eop on beat word_count. For word_count=1 both are asserted on the single beat.
- A beat transfers when src_valid & src_ready. src_data, src_valid, src_sop and src_eop hold while src_valid & !src_ready.
- done and busy:
  - done pulses, and busy falls, in the cycle following the eop transfer.
  - A start arriving in that same done cycle is accepted (busy was already 0 at the start of the cycle, so the block is idle).
- abort while busy:
  - Next cycle: state IDLE, busy=0, FIFO flushed, src_valid=0, no done pulse.
  - Any in-flight readdata is discarded.
  - start and abort together in IDLE: abort wins and the fetch is not started.
- reset mid-fetch behaves identically to abort and also clears done.

Decomposition:
- Package led_fetch_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, ZDONE);
  - default width constants ADDR_W=13, DATA_W=32, LEN_W=14;
  - localparam FIFO count width = clog2(FIFO_DEPTH)+1.
- One sub-module, led_fetch_fifo: synchronous FIFO with registered output, flush input, count output, no overflow protection. The caller guarantees it is never overfilled.

Test Plan:
- Nominal run: base_addr=0x0010, word_count=8, memory word k holds 0xA5000000+k, src_ready=1 → first src_valid 3 cycles after start; 8 contiguous beats 0xA5000010..0xA5000017; sop on beat 1, eop on beat 8; done pulses once; busy falls with done.
- Backpressure: word_count=16, src_ready toggles 1-0 every cycle (and separately held 0 for 20 cycles) → no word lost or duplicated; m_chipselect stalls once 4 words are buffered or in flight; data order preserved.
- Wrap and edge sizes: base_addr=0x1FFE with word_count=4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001. word_count=1 → single beat with sop=eop=1. word_count=0 → done 1 cycle after start, m_chipselect never asserted.
- Abort and reset: abort on cycle 5 of a 32-word fetch → next cycle busy=0, src_valid=0, no done. A following fetch from 0x0100 yields its own data as its first beat, not stale FIFO contents. Repeat the same sequence with reset in place of abort → same outcome.
- Protocol corners: start while busy → ignored and parameters unchanged. start in the same cycle as done → new fetch begins. start with abort in IDLE → nothing happens.
